// File: rtl/demux3vec_buf.sv
// demux3vec_buf: registered 1-to-3 vector demultiplexer.
// Routes one DEPTH-lane vector to writeback, store path or forwarding
// network. Each destination owns a one-entry holding register with a
// valid/ready handshake, so one stalled consumer never blocks the other two.
// Select value 3 is illegal: the vector is accepted and dropped, and the
// event is recorded in a sticky flag and a saturating 8-bit counter.
module demux3vec_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data   [0:DEPTH-1],
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data [0:DEPTH-1],
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data [0:DEPTH-1],
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2_data [0:DEPTH-1],
  output logic             err_sel,
  output logic [7:0]       drop_cnt
);

  localparam int NSLOT = 3;
  localparam logic [1:0] SEL_ILLEGAL = 2'd3;

  typedef logic [WIDTH-1:0] lanes_t [0:DEPTH-1];

  logic [NSLOT-1:0] valid_q, valid_d;
  lanes_t           data_q [NSLOT];
  lanes_t           data_d [NSLOT];
  logic             err_q, err_d;
  logic [7:0]       drop_q, drop_d;

  logic [NSLOT-1:0] out_ready;
  logic [NSLOT-1:0] drain;
  logic [NSLOT-1:0] fill;
  logic             fire;
  logic             illegal;

  assign out_ready = {out2_ready, out1_ready, out0_ready};
  assign drain     = valid_q & out_ready;
  assign fire      = in_valid & in_ready;
  assign illegal   = fire & (in_sel == SEL_ILLEGAL);

  // Accept when the selected slot is empty or being drained this cycle;
  // illegal selects are always accepted so the source never deadlocks.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    in_ready = 1'b1;
    case (in_sel)
      2'd0:    in_ready = ~valid_q[0] | out_ready[0];
      2'd1:    in_ready = ~valid_q[1] | out_ready[1];
      2'd2:    in_ready = ~valid_q[2] | out_ready[2];
      default: in_ready = 1'b1;
    endcase
  end

  // Per-slot next state: a fill wins over a drain (pass-through), a drain
  // alone empties the slot but leaves its data untouched.
  always_comb begin
    for (int k = 0; k < NSLOT; k++) begin
      fill[k]    = fire && (in_sel == 2'(k));
      valid_d[k] = fill[k] | (valid_q[k] & ~drain[k]);
      data_d[k]  = data_q[k];
      if (fill[k]) begin
        data_d[k] = in_data;
      end
    end
  end

  // Illegal-select bookkeeping: sticky flag and counter saturating at 255.
  always_comb begin
    err_d  = err_q | illegal;
    drop_d = drop_q;
    if (illegal && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // State registers; reset clears flags and every held lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      valid_q <= '0;
      err_q   <= 1'b0;
      drop_q  <= '0;
      // NOTE: the holding registers are visible outputs that must read zero in reset, so each lane is cleared explicitly.
      for (int k = 0; k < NSLOT; k++) begin
        for (int l = 0; l < DEPTH; l++) begin
          data_q[k][l] <= '0;
        end
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      for (int k = 0; k < NSLOT; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out0_valid = valid_q[0];
  assign out1_valid = valid_q[1];
  assign out2_valid = valid_q[2];
  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];
  assign out2_data  = data_q[2];
  assign err_sel    = err_q;
  assign drop_cnt   = drop_q;

endmodule

// File: doc/demux3vec_buf.md
Name: demux3vec_buf

Overview:
- Registered 1-to-3 vector demultiplexer: the counterpart of the 3-to-1 vector select used in the vector pipeline.
- Takes one vector result (DEPTH lanes of WIDTH bits) with a 2-bit destination select, and delivers it to one of three downstream consumers (writeback, memory store path, forwarding network).
- Each destination has a one-entry holding register with a valid/ready handshake, so a stalled consumer does not block transfers to the other two.

Parameters:
- WIDTH, 32, bits per vector lane.
- DEPTH, 4, number of lanes per vector.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  source presents a vector.
- in_ready  output  1  block accepts the vector this cycle.
- in_sel  input  2  destination: 00 → out0, 01 → out1, 10 → out2, 11 → illegal.
- in_data  input  WIDTH x [0:DEPTH-1]  unpacked lane array.
- outK_valid  output  1  (K=0,1,2) holding register K is full.
- outK_ready  input  1  (K=0,1,2) consumer K takes the vector.
- outK_data  output  WIDTH x [0:DEPTH-1]  (K=0,1,2) content of holding register K.
- err_sel  output  1  sticky: an in_sel=11 transfer was accepted.
- drop_cnt  output  8  count of illegal-select transfers.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outK_valid = 0.
  - All outK_data lanes = 0.
  - err_sel = 0, drop_cnt = 0.
  - Takes effect immediately, mid-transfer included; in-flight held vectors are discarded.
- Slot K:
  - Drain: drains when outK_valid & outK_ready.
  - Fill: fills when the input fires (in_valid & in_ready) with in_sel=K.
- in_ready is combinational:
  - in_sel=K: in_ready = ~outK_valid | outK_ready. Pass-through on drain; one vector per cycle sustained per destination.
  - in_sel=11: in_ready = 1 always.
- Slot K next state:
  - fill & drain: valid stays 1, data ← in_data.
  - fill only: valid ← 1, data ← in_data.
  - drain only: valid ← 0, data unchanged.
  - neither: hold.
- Latency: 1 cycle from input fire to outK_valid=1. No combinational path from in_data to outK_data.
- Independent slots: concurrent drains on all three outputs plus a fill of one slot in the same cycle are legal.
- Data is captured only on fire. in_data and in_sel are don't-care when in_valid=0.
- Illegal select (fire with in_sel=11):
  - Data is dropped and no slot changes.
  - err_sel ← 1 (sticky until reset).
  - drop_cnt increments and saturates at 255.
- in_sel changing while in_valid is held with in_ready=0: permitted. in_ready re-evaluates against the newly selected slot.
- outK_data is stable while outK_valid=1 and outK_ready=0.

Test Plan:
- Reset/idle: assert rst_n=0 mid-simulation with out1 full → out*_valid=0 and lanes=0 immediately, before the next edge; err_sel=0, drop_cnt=0.
- Basic routing: with all readys=1, send lanes {0,1,2,3} sel=00, {4,5,6,7} sel=01, {8,9,10,11} sel=10 on consecutive cycles → each appears on out0/out1/out2 exactly one cycle after its fire, with lanes matching.
- Backpressure: out1_ready=0, send {4,5,6,7} sel=01 → out1_valid=1. A second sel=01 vector sees in_ready=0 and out1_data holds {4,5,6,7}. Raise out1_ready → second vector accepted that same cycle and appears the next cycle.
- Independence: out0 stalled and full, send sel=10 {8,9,10,11} → in_ready=1, and out2 gets the data while out0 is unchanged.
- Pass-through throughput: out2_ready=1 constantly, stream 10 vectors with sel=10 → in_ready=1 every cycle, 10 distinct vectors out in order with no bubbles.
- Illegal select: 3 fires with sel=11 → no outK_valid change, err_sel=1, drop_cnt=3. 300 such fires → drop_cnt=255.
